// File: rtl/chi_round.sv
// ---------------------------------------------------------------------------
// chi_round -- Keccak-f chi step, one plane (5 lanes sharing y) per clock.
//
// Computes A'[x,y] = A[x,y] ^ (~A[x+1,y] & A[x+2,y]) with x taken mod 5.
// The input state is captured into src_buf when an operation starts, then
// planes y = 0..4 are written into chi_transform on five consecutive edges.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   start         level request, sampled only in IDLE and DONE
//   state         input state, lane(x,y) at [LANE_W*(5y+x) +: LANE_W]
//   busy          high while planes are being computed
//   done          result valid / acknowledge
//   chi_transform output state, same lane layout as state
//
// Handshake: start is a level request. The block captures state on the first
// edge that sees start=1 in IDLE, raises busy for 5 cycles, then raises done
// and holds it (with a stable result) for as long as start stays high. When
// start is low at an edge in DONE, done falls and the block returns to IDLE,
// so start must drop for at least one edge between operations.
// ---------------------------------------------------------------------------
module chi_round #(
   parameter int LANE_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [25*LANE_W-1:0]  state,
   output logic                  busy,
   output logic                  done,
   output logic [25*LANE_W-1:0]  chi_transform
);

   localparam int SW = 25 * LANE_W;
   localparam int PW = 5 * LANE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t          fsm;
   logic [2:0]    p;
   logic [SW-1:0] src_buf;
   logic [PW-1:0] plane_in;
   logic [PW-1:0] plane_out;

   // Select the plane currently being processed from the captured state.
   always_comb begin
      case (p)
         3'd1:    plane_in = src_buf[1*PW +: PW];
         3'd2:    plane_in = src_buf[2*PW +: PW];
         3'd3:    plane_in = src_buf[3*PW +: PW];
         3'd4:    plane_in = src_buf[4*PW +: PW];
         default: plane_in = src_buf[0 +: PW];
      endcase
   end

   // Chi on one plane: each lane mixes with its two right-hand neighbours.
   always_comb begin
      plane_out = '0;
      for (int x = 0; x < 5; x++) begin
         plane_out[x*LANE_W +: LANE_W] =
            plane_in[x*LANE_W +: LANE_W] ^
            (~plane_in[((x+1)%5)*LANE_W +: LANE_W] &
              plane_in[((x+2)%5)*LANE_W +: LANE_W]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm           <= IDLE;
         p             <= 3'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         chi_transform <= '0;
         src_buf       <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  src_buf <= state;
                  p       <= 3'd0;
                  busy    <= 1'b1;
                  fsm     <= RUN;
               end
            end
            RUN: begin
               // Only the current plane is written; other planes keep
               // whatever they held, so the output is valid only with done.
               case (p)
                  3'd0: chi_transform[0*PW +: PW] <= plane_out;
                  3'd1: chi_transform[1*PW +: PW] <= plane_out;
                  3'd2: chi_transform[2*PW +: PW] <= plane_out;
                  3'd3: chi_transform[3*PW +: PW] <= plane_out;
                  3'd4: chi_transform[4*PW +: PW] <= plane_out;
                  default: ;
               endcase
               // >= rather than == so a corrupted counter still terminates.
               if (p >= 3'd4) begin
                  p    <= 3'd0;
                  busy <= 1'b0;
                  done <= 1'b1;
                  fsm  <= DONE;
               end else begin
                  p <= p + 3'd1;
               end
            end
            DONE: begin
               if (!start) begin
                  done <= 1'b0;
                  fsm  <= IDLE;
               end
            end
            default: begin
               fsm  <= IDLE;
               p    <= 3'd0;
               busy <= 1'b0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chi_round.sv
// ---------------------------------------------------------------------------
// tb_chi_round -- self-checking bench for chi_round (LANE_W = 64).
// Expected results are pushed into exp_q when an operation is issued; a
// monitor pops and compares on every rising edge of done.
// ---------------------------------------------------------------------------
module tb_chi_round;

   localparam int LANE_W = 64;
   localparam int SW     = 25 * LANE_W;

   logic          clk;
   logic          rst;
   logic          start;
   logic [SW-1:0] state;
   logic          busy;
   logic          done;
   logic [SW-1:0] chi_transform;

   logic [SW-1:0] exp_q[$];
   int            n_checks;
   int            n_pass;

   chi_round #(.LANE_W(LANE_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .state         (state),
      .busy          (busy),
      .done          (done),
      .chi_transform (chi_transform)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic logic [SW-1:0] chi_ref(input logic [SW-1:0] a);
      logic [SW-1:0]     r;
      logic [LANE_W-1:0] l [5];
      r = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) l[x] = a[LANE_W*(5*y+x) +: LANE_W];
         for (int x = 0; x < 5; x++)
            r[LANE_W*(5*y+x) +: LANE_W] = l[x] ^ (~l[(x+1)%5] & l[(x+2)%5]);
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] rand_state();
      logic [SW-1:0] r;
      for (int i = 0; i < SW; i += 8) r[i +: 8] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   // ---------------- checkers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic check_wide(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      int l;
      n_checks++;
      if (act === exp) n_pass++;
      else begin
         l = 0;
         for (int i = 24; i >= 0; i--)
            if (act[LANE_W*i +: LANE_W] !== exp[LANE_W*i +: LANE_W]) l = i;
         $display("FAIL %s: lane %0d got %h, want %h", name, l,
                  act[LANE_W*l +: LANE_W], exp[LANE_W*l +: LANE_W]);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic          done_q;
      logic [SW-1:0] e;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !done_q) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check_wide("result", chi_transform, e);
            end
         end
         done_q = done;
      end
   end

   // ---------------- driver ----------------
   // Issues one operation. drop_at >= 0 drops start after that RUN cycle;
   // otherwise start is held for 'hold' cycles after done rises.
   task automatic op(input logic [SW-1:0] v, input logic [SW-1:0] exp,
                     input int drop_at, input bit scramble, input int hold);
      int bc;
      bit early;
      state = v;
      start = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);                       // capture edge
      bc    = 0;
      early = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (c == drop_at) start = 1'b0;
         if (scramble) state = rand_state();
         @(negedge clk);
         bc += int'(busy);
         if (done) early = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      check("busy_cycles", 64'(bc), 64'd5);
      check("done_early", 64'(early), 64'd0);
      check("done_rise", 64'(done), 64'd1);
      check("busy_fall", 64'(busy), 64'd0);
      if (drop_at < 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_hold", 64'(done), 64'd1);
            check_wide("result_hold", chi_transform, exp);
         end
         start = 1'b0;
      end
      @(negedge clk);
      check("done_fall", 64'(done), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [SW-1:0] v;
      logic [SW-1:0] e;
      n_checks = 0;
      n_pass   = 0;

      // Reset held with start high: nothing may happen.
      rst   = 1'b0;
      start = 1'b1;
      v     = rand_state();
      state = v;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check_wide("rst_out", chi_transform, '0);
      @(posedge clk);
      #1 rst = 1'b1;
      op(v, chi_ref(v), -1, 1'b0, 0);       // captured on first edge after release

      // All zeros and all ones map to themselves.
      op('0, '0, -1, 1'b0, 0);
      op('1, '1, -1, 1'b0, 0);

      // Single bit in lane(1,0): lanes (1,0) and (4,0) bit 0.
      v = '0; v[64] = 1'b1;
      e = '0; e[64] = 1'b1; e[256] = 1'b1;
      op(v, e, -1, 1'b0, 0);
      // Same in plane 4.
      v = '0; v[64*21] = 1'b1;
      e = '0; e[64*21] = 1'b1; e[64*24] = 1'b1;
      op(v, e, -1, 1'b0, 0);

      // Start held 20 cycles in DONE; then start dropped at RUN cycle 2.
      v = rand_state();
      op(v, chi_ref(v), -1, 1'b0, 20);
      v = rand_state();
      op(v, chi_ref(v), 2, 1'b0, 0);

      // Input changes every cycle during RUN.
      v = rand_state();
      op(v, chi_ref(v), -1, 1'b1, 0);

      // Asynchronous abort mid-RUN.
      state = rand_state();
      start = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check_wide("abort_out", chi_transform, '0);
      start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      v = rand_state();
      op(v, chi_ref(v), -1, 1'b0, 0);

      // Random regression.
      for (int i = 0; i < 1000; i++) begin
         v = rand_state();
         op(v, chi_ref(v), int'($urandom_range(0, 5)) - 1, 1'(i % 7 == 0), 0);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
